// File: rtl/led_panel.sv
// led_panel: memory-mapped front-panel LED peripheral on the CPU6 system bus.
// Decodes CPU writes to an 8-byte window at BASE and drives eight LEDs from a
// latched register, or from the live memory read-data bus in monitor mode.
// Optional PWM dimming is compiled in by defining LED_PANEL_PWM_EN.
module led_panel #(
    parameter logic [18:0] BASE = 19'h0F200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    input  logic [7:0]  mem_data,
    output logic [7:0]  leds
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_SET    = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_TOG    = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
`ifdef LED_PANEL_PWM_EN
    localparam logic [2:0] OFF_BRIGHT = 3'd5;
`endif

    logic [DW-1:0] led_q,  led_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] mon_q;
    logic          hit_c;
    logic          wr_c;
    logic [DW-1:0] src_c;
    logic          pwm_on_c;

    // Window decode; reset dominance is handled in the register block
    assign hit_c = (address[18:3] == BASE[18:3]);
    assign wr_c  = hit_c & write_en;

`ifdef LED_PANEL_PWM_EN
    logic [DW-1:0] bright_q, bright_d;
    logic [DW-1:0] pwm_cnt_q;
`endif

    // Next-state for the software-visible registers
    always_comb begin
        led_d  = led_q;
        ctrl_d = ctrl_q;
`ifdef LED_PANEL_PWM_EN
        bright_d = bright_q;
`endif
        if (wr_c) begin
            case (address[2:0])
                OFF_DATA:   led_d  = data_in;
                OFF_SET:    led_d  = led_q | data_in;
                OFF_CLR:    led_d  = led_q & ~data_in;
                OFF_TOG:    led_d  = led_q ^ data_in;
                OFF_CTRL:   ctrl_d = data_in[CW-1:0];
`ifdef LED_PANEL_PWM_EN
                OFF_BRIGHT: bright_d = data_in;
`endif
                default:    ;
            endcase
        end
    end

    // Register update; monitor latch samples mem_data every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q  <= '0;
            ctrl_q <= '0;
            mon_q  <= '0;
        end else begin
            led_q  <= led_d;
            ctrl_q <= ctrl_d;
            mon_q  <= mem_data;
        end
    end

`ifdef LED_PANEL_PWM_EN
    // Free-running PWM counter and brightness threshold
    always_ff @(posedge clock) begin
        if (reset) begin
            bright_q  <= 8'hFF;
            pwm_cnt_q <= '0;
        end else begin
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_q + DW'(1);
        end
    end

    assign pwm_on_c = (pwm_cnt_q < bright_q);
`else
    assign pwm_on_c = 1'b1;
`endif

    // LED drive: source select, PWM gate, then optional inversion
    assign src_c = ctrl_q[0] ? mon_q : led_q;
    assign leds  = (src_c & {DW{pwm_on_c}}) ^ {DW{ctrl_q[1]}};

endmodule

// File: tb/tb_led_panel.sv
// tb_led_panel: directed test-plan steps plus randomized bus traffic, all
// checked against a behavioural model of the LED panel. Honours
// LED_PANEL_PWM_EN the same way the design does.
module tb_led_panel;

    localparam logic [18:0] BASE = 19'h0F200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] address = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  mem_data = '0;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_led, m_mon, m_bright;
    logic       m_mon_en, m_inv;
    int         m_cyc;        // clock edges since the last reset edge
    logic [7:0] md_cur = '0;
    int         on_cnt;

    led_panel #(.BASE(BASE)) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .mem_data (mem_data),
        .leds     (leds)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gate();
`ifdef LED_PANEL_PWM_EN
        return ((m_cyc % 256) < int'(m_bright)) ? 8'hFF : 8'h00;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [7:0] model_leds();
        logic [7:0] src;
        src = m_mon_en ? m_mon : m_led;
        return (src & gate()) ^ (m_inv ? 8'hFF : 8'h00);
    endfunction

    // Expected LED value for a known source value under the model's current gate/inversion
    task automatic chk_src(input string tag, input logic [7:0] src);
        check(tag, 32'(leds), 32'((src & gate()) ^ (m_inv ? 8'hFF : 8'h00)));
    endtask

    task automatic model_edge(input logic r, input logic [18:0] a, input logic w,
                              input logic [7:0] d, input logic [7:0] md);
        if (r) begin
            m_led = 8'h00; m_mon = 8'h00; m_bright = 8'hFF;
            m_mon_en = 1'b0; m_inv = 1'b0; m_cyc = 0;
        end else begin
            if (w && (a / 8) == (BASE / 8)) begin
                case (a % 8)
                    0: m_led = d;
                    1: m_led = m_led | d;
                    2: m_led = m_led & ~d;
                    3: m_led = m_led ^ d;
                    4: begin m_mon_en = d[0]; m_inv = d[1]; end
`ifdef LED_PANEL_PWM_EN
                    5: m_bright = d;
`endif
                    default: ;
                endcase
            end
            m_mon = md;
            m_cyc++;
        end
    endtask

    task automatic step(input logic r, input logic [18:0] a, input logic w,
                        input logic [7:0] d, input logic [7:0] md);
        @(negedge clock);
        reset = r; address = a; write_en = w; data_in = d; mem_data = md;
        @(posedge clock);
        model_edge(r, a, w, d, md);
        #1;
        check("model", 32'(leds), 32'(model_leds()));
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        step(1'b0, BASE | 19'(off), 1'b1, d, md_cur);
    endtask

    task automatic idle();
        step(1'b0, BASE, 1'b0, 8'h00, md_cur);
    endtask

    initial begin
        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1, BASE, 1'b0, 8'h00, 8'h00);
            check("reset_hold", 32'(leds), 32'h00);
        end
        idle();
        check("reset_release", 32'(leds), 32'h00);

        // DATA / SET / CLR / TOG
        wr(3'd0, 8'h81); chk_src("data", 8'h81);
        wr(3'd1, 8'h18); chk_src("set",  8'h99);
        wr(3'd2, 8'h01); chk_src("clr",  8'h98);
        wr(3'd3, 8'hFF); chk_src("tog",  8'h67);

        // Decode misses
        step(1'b0, 19'h0F208, 1'b1, 8'h55, md_cur); chk_src("miss_above", 8'h67);
        step(1'b0, 19'h0F1FF, 1'b1, 8'h55, md_cur); chk_src("miss_below", 8'h67);
        wr(3'd6, 8'h55); chk_src("off6", 8'h67);
        wr(3'd7, 8'h55); chk_src("off7", 8'h67);
        step(1'b0, BASE, 1'b0, 8'h55, md_cur); chk_src("no_we", 8'h67);

        // CTRL: invert, then monitor with 1-cycle latency
        wr(3'd0, 8'h0F);
        wr(3'd4, 8'h02); chk_src("inv", 8'h0F);
        md_cur = 8'hA5;
        wr(3'd4, 8'h01); chk_src("mon_a5", 8'hA5);
        md_cur = 8'h3C;
        idle(); chk_src("mon_3c", 8'h3C);
        wr(3'd4, 8'h00);

        // Duty with default brightness, then BRIGHT=0x40, then BRIGHT=0
        wr(3'd0, 8'hFF);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin idle(); if (leds === 8'hFF) on_cnt++; end
`ifdef LED_PANEL_PWM_EN
        check("duty_ff", 32'(on_cnt), 32'd255);
`else
        check("duty_ff", 32'(on_cnt), 32'd256);
`endif
        wr(3'd5, 8'h40);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin idle(); if (leds === 8'hFF) on_cnt++; end
`ifdef LED_PANEL_PWM_EN
        check("duty_40", 32'(on_cnt), 32'd64);
`else
        check("duty_40", 32'(on_cnt), 32'd256);
`endif
        wr(3'd5, 8'h00);
        on_cnt = 0;
        for (int i = 0; i < 64; i++) begin idle(); if (leds === 8'hFF) on_cnt++; end
`ifdef LED_PANEL_PWM_EN
        check("duty_00", 32'(on_cnt), 32'd0);
`else
        check("duty_00", 32'(on_cnt), 32'd64);
`endif

        // Reset together with a write: reset wins
        step(1'b1, BASE, 1'b1, 8'hFF, md_cur);
        check("reset_vs_write", 32'(leds), 32'h00);
        idle();
        check("after_reset_write", 32'(leds), 32'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic [18:0] a;
            logic [2:0]  off;
            off = 3'($urandom_range(0, 7));
            r   = ($urandom_range(0, 59) == 0);
            a   = ($urandom_range(0, 4) == 0) ? 19'($urandom) : (BASE | 19'(off));
            md_cur = 8'($urandom);
            step(r, a, 1'($urandom_range(0, 3) != 0), 8'($urandom), md_cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
